// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, instruction codes and the
// data-memory responder state encoding.
package y86_pkg;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake between the memory stage and the data memory.
interface dmem_responder_if;
    import y86_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/dmem_array.sv
// Byte-addressed storage with one 8-byte little-endian read port and one
// 8-byte write port; contents are never reset.
module dmem_array
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [7:0] mem_r [MEM_BYTES];

    // All eight bytes of a quadword are committed on the same edge
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem_r[waddr + AW'(i)] <= wdata[8*i +: 8];
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                mem_r[waddr + AW'(i)] <= mem_r[waddr + AW'(i)];
            end
        end
    end

    // Asynchronous little-endian quadword read
    always_comb begin
        rdata = 64'd0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem_r[raddr + AW'(i)];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one quadword access at a time,
// performs it LATENCY edges later and holds the response until taken.
module dmem_responder
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus
);

    localparam int AW = $clog2(MEM_BYTES);
    // Plain compare against the last legal base avoids the wrap an addr+8 test would hit
    localparam logic [63:0] LAST_BASE = 64'(MEM_BYTES - 8);

    logic [1:0]  state_r;
    logic [3:0]  cnt_r;
    logic        wr_r;
    logic [63:0] addr_r;
    logic [63:0] wdata_r;
    logic [63:0] rdata_r;
    logic        err_r;
    logic        req_ready_r;
    logic        resp_valid_r;

    logic        addr_err_s;
    logic        perform_s;
    logic        mem_we_s;
    logic [63:0] mem_rdata_s;

    // Access strobe and address-range check on the latched request
    always_comb begin
        addr_err_s = (addr_r > LAST_BASE);
        perform_s  = (state_r == ST_WAIT) && (cnt_r == 4'd1);
        if (perform_s && wr_r && !addr_err_s && !rst) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    dmem_array #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (addr_r[AW-1:0]),
        .wdata (wdata_r),
        .raddr (addr_r[AW-1:0]),
        .rdata (mem_rdata_s)
    );

    // Request/response FSM with latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            wr_r         <= 1'b0;
            addr_r       <= 64'd0;
            wdata_r      <= 64'd0;
            rdata_r      <= 64'd0;
            err_r        <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        wr_r        <= bus.req_write;
                        addr_r      <= bus.req_addr;
                        wdata_r     <= bus.req_wdata;
                        cnt_r       <= 4'(LATENCY);
                        req_ready_r <= 1'b0;
                        state_r     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd1) begin
                        err_r        <= addr_err_s;
                        rdata_r      <= (wr_r || addr_err_s) ? 64'd0 : mem_rdata_s;
                        cnt_r        <= 4'd0;
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= 4'd0;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_error = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-array reference model predicts
// every response, which is compared when resp_valid appears.
module tb_dmem_responder;
    import y86_pkg::*;

    localparam int MEM_BYTES = 1024;
    localparam int LATENCY   = 2;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    dmem_responder_if bus ();

    dmem_responder #(
        .MEM_BYTES (MEM_BYTES),
        .LATENCY   (LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];
    logic [7:0] model [MEM_BYTES];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
        check({tag, "_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_rdata"}, bus.resp_rdata, 64'd0);
        check({tag, "_error"}, 64'(bus.resp_error), 64'd0);
    endtask

    // Drive one request, predict it, wait for the response, hold it for
    // hold_cycles with resp_ready low, then complete the handshake.
    task automatic xact(input string tag, input logic wr, input logic [63:0] addr,
                        input logic [63:0] data, input int hold_cycles);
        exp_t e;
        exp_t got;
        logic bad;
        int   lat;
        @(negedge clk);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bad = (addr > 64'(MEM_BYTES - 8));
        e.err   = bad;
        e.rdata = 64'd0;
        if (!bad && !wr) begin
            for (int i = 0; i < 8; i++) e.rdata[8*i +: 8] = model[int'(addr) + i];
        end
        if (!bad && wr) begin
            for (int i = 0; i < 8; i++) model[int'(addr) + i] = data[8*i +: 8];
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
            check({tag, "_busy"}, 64'(bus.req_ready), 64'd0);
        end
        check({tag, "_latency"}, 64'(lat), 64'(LATENCY));
        if (lat == 0) return;
        got = sb_q.pop_front();
        check({tag, "_rdata"}, bus.resp_rdata, got.rdata);
        check({tag, "_error"}, 64'(bus.resp_error), 64'(got.err));
        for (int h = 0; h < hold_cycles; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 64'(bus.resp_valid), 64'd1);
            check({tag, "_hold_rdata"}, bus.resp_rdata, got.rdata);
            check({tag, "_hold_ready"}, 64'(bus.req_ready), 64'd0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check({tag, "_done_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_done_ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rd;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < MEM_BYTES; i++) model[i] = 8'h00;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        xact("clr18", 1'b1, 64'h18, 64'h0, 0);
        xact("wr10",  1'b1, 64'h10, 64'h0123456789ABCDEF, 0);
        xact("rd10",  1'b0, 64'h10, 64'h0, 0);
        xact("rd11",  1'b0, 64'h11, 64'h0, 0);

        xact("wr3f8",  1'b1, 64'h3F8, 64'h1122334455667788, 0);
        xact("rd3f8",  1'b0, 64'h3F8, 64'h0, 0);
        xact("wr3f9",  1'b1, 64'h3F9, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        xact("rd3f8b", 1'b0, 64'h3F8, 64'h0, 0);
        xact("wrap",   1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0);

        xact("bp_rd10", 1'b0, 64'h10, 64'h0, 5);

        for (int r = 0; r < 4; r++) begin
            ra = 64'($urandom_range(MEM_BYTES - 8, 64));
            rd = {$urandom, $urandom};
            xact("rnd_wr", 1'b1, ra, rd, 0);
            xact("rnd_rd", 1'b0, ra, 64'h0, r);
        end

        // Abort a write one edge after acceptance; it must never land
        xact("clr20", 1'b1, 64'h20, 64'h0, 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 64'h20;
        bus.req_wdata = 64'hAA;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("rst_wait");
        xact("rd20", 1'b0, 64'h20, 64'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
